// File: rtl/inst_fetch_queue.sv
// Instruction fetch unit with a prefetch FIFO between a 1-cycle synchronous-read
// instruction memory and a valid/ready decode interface; jumps flush and refetch.
module inst_fetch_queue #(
   parameter int          MEM_AW     = 10,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   localparam int         CW         = $clog2(FIFO_DEPTH + 1),
   localparam int         PW         = $clog2(FIFO_DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              jmp_vld,
   input  logic [31:0]       jmp_addr,
   output logic              mem_req,
   output logic [MEM_AW-1:0] mem_addr,
   input  logic [31:0]       mem_rdata,
   output logic              if_vld,
   input  logic              if_ready,
   output logic [31:0]       if_pc,
   output logic [31:0]       if_inst,
   output logic [CW-1:0]     fifo_cnt
);

   localparam logic [CW:0]   DEPTH_C = (CW + 1)'(FIFO_DEPTH);
   localparam logic [PW-1:0] LAST_C  = PW'(FIFO_DEPTH - 1);

   logic [31:0]   fpc_q, fpc_d;
   logic          infl_q, infl_d;
   logic [31:0]   infl_pc_q, infl_pc_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [31:0]   pc_mem   [FIFO_DEPTH];
   logic [31:0]   inst_mem [FIFO_DEPTH];

   logic [31:0]   jmp_tgt;
   logic          pop;
   logic          push;
   logic [CW:0]   occ_after;
   logic          unused_jmp_lsb;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_C) ? '0 : p + 1'b1;
   endfunction

   assign jmp_tgt        = {jmp_addr[31:2], 2'b00};
   assign unused_jmp_lsb = ^jmp_addr[1:0];

   assign if_vld  = (cnt_q != '0);
   assign if_pc   = if_vld ? pc_mem[rd_ptr_q]   : '0;
   assign if_inst = if_vld ? inst_mem[rd_ptr_q] : '0;
   assign fifo_cnt = cnt_q;

   assign pop  = if_vld & if_ready & ~jmp_vld;
   assign push = infl_q & ~jmp_vld;

   // Occupancy once this cycle's return and pop settle; issuing now needs a free slot then.
   assign occ_after = {1'b0, cnt_q} + (CW + 1)'(infl_q) - (CW + 1)'(pop);
   assign mem_req   = ~rst & (jmp_vld | (occ_after < DEPTH_C));
   assign mem_addr  = jmp_vld ? jmp_tgt[MEM_AW+1:2] : fpc_q[MEM_AW+1:2];

   // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
   always_comb begin
      fpc_d     = fpc_q;
      infl_d    = 1'b0;
      infl_pc_d = infl_pc_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      cnt_d     = cnt_q;
      if (jmp_vld) begin
         fpc_d     = jmp_tgt + 32'd4;
         infl_d    = 1'b1;
         infl_pc_d = jmp_tgt;
         rd_ptr_d  = '0;
         wr_ptr_d  = '0;
         cnt_d     = '0;
      end else begin
         if (mem_req) begin
            fpc_d     = fpc_q + 32'd4;
            infl_d    = 1'b1;
            infl_pc_d = fpc_q;
         end
         if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fpc_q     <= RESET_PC;
         infl_q    <= 1'b0;
         infl_pc_q <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         cnt_q     <= '0;
      end else begin
         fpc_q     <= fpc_d;
         infl_q    <= infl_d;
         infl_pc_q <= infl_pc_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         cnt_q     <= cnt_d;
      end
   end

   // NOTE: queue storage is not reset; cnt_q gates every read, so stale words are never visible.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr_q]   <= infl_pc_q;
         inst_mem[wr_ptr_q] <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed vector table, queue-model
// random run, async reset pulse, and address wrap on a narrow-memory instance.
module tb_inst_fetch_queue;

   localparam int AW     = 10;
   localparam int DEPTH  = 4;
   localparam int AW2    = 4;
   localparam int DEPTH2 = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          jmp_vld = 1'b0;
   logic [31:0]   jmp_addr = '0;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_rdata = '0;
   logic          if_vld;
   logic          if_ready = 1'b1;
   logic [31:0]   if_pc;
   logic [31:0]   if_inst;
   logic [2:0]    fifo_cnt;

   logic           jmp_vld2 = 1'b0;
   logic [31:0]    jmp_addr2 = '0;
   logic           mem_req2;
   logic [AW2-1:0] mem_addr2;
   logic [31:0]    mem_rdata2 = '0;
   logic           if_vld2;
   logic           if_ready2 = 1'b1;
   logic [31:0]    if_pc2;
   logic [31:0]    if_inst2;
   logic [1:0]     fifo_cnt2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   inst_fetch_queue #(.MEM_AW(AW), .FIFO_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .jmp_vld(jmp_vld), .jmp_addr(jmp_addr),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .if_vld(if_vld), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
      .fifo_cnt(fifo_cnt));

   inst_fetch_queue #(.MEM_AW(AW2), .FIFO_DEPTH(DEPTH2), .RESET_PC(32'h0)) dut2 (
      .clk(clk), .rst(rst), .jmp_vld(jmp_vld2), .jmp_addr(jmp_addr2),
      .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_rdata(mem_rdata2),
      .if_vld(if_vld2), .if_ready(if_ready2), .if_pc(if_pc2), .if_inst(if_inst2),
      .fifo_cnt(fifo_cnt2));

   // Instruction memories: word n holds 0xA000_0000+n, one-cycle read latency.
   always @(posedge clk) begin
      mem_rdata  <= mem_req  ? 32'hA000_0000 + 32'(mem_addr)  : 32'hDEAD_BEEF;
      mem_rdata2 <= mem_req2 ? 32'hA000_0000 + 32'(mem_addr2) : 32'hDEAD_BEEF;
   end

   function automatic logic [31:0] word_of(input logic [31:0] pc, input int aw);
      return 32'hA000_0000 + ((pc >> 2) & ((32'd1 << aw) - 32'd1));
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      jmp_vld  = 1'b0;
      jmp_addr = '0;
      if_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   typedef struct {
      logic        jmp;
      logic [31:0] tgt;
      logic        rdy;
      logic        vld;
      logic [31:0] pc;
      int          cnt;
      logic        req;
      logic [31:0] addr;
   } vec_t;

   vec_t vecs[15];

   // Reference model: queue of delivered-pc candidates plus the outstanding request.
   logic [31:0] m_q[$];
   bit          m_infl;
   logic [31:0] m_infl_pc;
   logic [31:0] m_fpc;

   initial begin
      //            jmp  tgt         rdy  vld pc        cnt req addr
      vecs[0]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   0, 1'b1, 32'h0};
      vecs[1]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   0, 1'b1, 32'h1};
      vecs[2]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1, 1'b1, 32'h2};
      vecs[3]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h4,   1, 1'b1, 32'h3};
      vecs[4]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h4,   2, 1'b1, 32'h4};
      vecs[5]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h4,   3, 1'b0, 32'h0};
      vecs[6]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h4,   4, 1'b0, 32'h0};
      vecs[7]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   4, 1'b1, 32'h5};
      vecs[8]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   3, 1'b1, 32'h6};
      vecs[9]  = '{1'b1, 32'h100, 1'b1, 1'b1, 32'hC,   3, 1'b1, 32'h40};
      vecs[10] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   0, 1'b1, 32'h41};
      vecs[11] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1, 1'b1, 32'h42};
      vecs[12] = '{1'b1, 32'h203, 1'b1, 1'b1, 32'h104, 1, 1'b1, 32'h80};
      vecs[13] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   0, 1'b1, 32'h81};
      vecs[14] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 1, 1'b1, 32'h82};

      // Directed table: startup, stall to full, jump with queue occupied, misaligned jump.
      do_reset();
      for (int i = 0; i < 15; i++) begin
         jmp_vld  = vecs[i].jmp;
         jmp_addr = vecs[i].tgt;
         if_ready = vecs[i].rdy;
         @(negedge clk);
         check("tbl_if_vld", 32'(if_vld), 32'(vecs[i].vld));
         check("tbl_if_pc", if_pc, vecs[i].pc);
         check("tbl_if_inst", if_inst, vecs[i].vld ? word_of(vecs[i].pc, AW) : 32'h0);
         check("tbl_fifo_cnt", 32'(fifo_cnt), 32'(vecs[i].cnt));
         check("tbl_mem_req", 32'(mem_req), 32'(vecs[i].req));
         if (vecs[i].req) check("tbl_mem_addr", 32'(mem_addr), vecs[i].addr);
         @(posedge clk);
         #1;
      end

      // Randomised run against the queue model.
      do_reset();
      m_q.delete();
      m_infl = 1'b0;
      m_infl_pc = '0;
      m_fpc = 32'h0;
      for (int i = 0; i < 3000; i++) begin
         logic        e_vld, e_pop, e_req;
         logic [31:0] e_pc, tgt;
         jmp_vld  = ($urandom_range(0, 19) == 0);
         jmp_addr = $urandom;
         if_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         tgt   = {jmp_addr[31:2], 2'b00};
         e_vld = (m_q.size() != 0);
         e_pc  = e_vld ? m_q[0] : 32'h0;
         e_pop = e_vld & if_ready & ~jmp_vld;
         e_req = jmp_vld | ((m_q.size() + int'(m_infl) - int'(e_pop)) < DEPTH);
         check("rnd_if_vld", 32'(if_vld), 32'(e_vld));
         check("rnd_if_pc", if_pc, e_pc);
         check("rnd_if_inst", if_inst, e_vld ? word_of(e_pc, AW) : 32'h0);
         check("rnd_fifo_cnt", 32'(fifo_cnt), 32'(m_q.size()));
         check("rnd_mem_req", 32'(mem_req), 32'(e_req));
         if (e_req)
            check("rnd_mem_addr", 32'(mem_addr),
                  ((jmp_vld ? tgt : m_fpc) >> 2) & ((32'd1 << AW) - 32'd1));
         if (jmp_vld) begin
            m_q.delete();
            m_infl    = 1'b1;
            m_infl_pc = tgt;
            m_fpc     = tgt + 32'd4;
         end else begin
            if (e_pop) void'(m_q.pop_front());
            if (m_infl) m_q.push_back(m_infl_pc);
            m_infl = e_req;
            if (e_req) begin
               m_infl_pc = m_fpc;
               m_fpc     = m_fpc + 32'd4;
            end
         end
         @(posedge clk);
         #1;
      end

      // Asynchronous reset pulse between clock edges with the queue filled.
      jmp_vld  = 1'b0;
      if_ready = 1'b0;
      repeat (6) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_if_vld", 32'(if_vld), 32'h0);
      check("arst_mem_req", 32'(mem_req), 32'h0);
      check("arst_fifo_cnt", 32'(fifo_cnt), 32'h0);
      @(posedge clk);
      #2 rst = 1'b0;
      if_ready = 1'b1;
      @(negedge clk);
      check("arst_restart_req", 32'(mem_req), 32'h1);
      check("arst_restart_addr", 32'(mem_addr), 32'h0);
      check("arst_restart_vld0", 32'(if_vld), 32'h0);
      @(negedge clk);
      check("arst_restart_vld1", 32'(if_vld), 32'h0);
      @(negedge clk);
      check("arst_restart_vld2", 32'(if_vld), 32'h1);
      check("arst_restart_pc", if_pc, 32'h0);
      check("arst_restart_inst", if_inst, 32'hA000_0000);

      // Narrow memory: word address wraps while the pc keeps counting.
      do_reset();
      for (int k = 0; k < 22; k++) begin
         @(negedge clk);
         check("wrap_mem_req", 32'(mem_req2), 32'h1);
         check("wrap_mem_addr", 32'(mem_addr2), 32'(k % 16));
         if (k >= 2) begin
            check("wrap_if_vld", 32'(if_vld2), 32'h1);
            check("wrap_if_pc", if_pc2, 32'((k - 2) * 4));
            check("wrap_if_inst", if_inst2, 32'hA000_0000 + 32'((k - 2) % 16));
         end
         @(posedge clk);
         #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
